// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store request at a time against a word array,
// with byte-lane steering, sign/zero extension, write masking and fault reporting.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_oper_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic [4:0]  rsp_exc_o
);
    localparam int unsigned AW   = $clog2(4 * DEPTH_WORDS);
    localparam int unsigned IW   = (AW > 2) ? AW - 2 : 1;
    localparam logic [32:0] SPAN = 33'(4) * 33'(DEPTH_WORDS);

    // mem_oper_t encodings
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_NOP = 4'b1111;

    // exc_t codes
    localparam logic [4:0] EXC_LD_MISALIGN = 5'd4;
    localparam logic [4:0] EXC_LD_FAULT    = 5'd5;
    localparam logic [4:0] EXC_ST_MISALIGN = 5'd6;
    localparam logic [4:0] EXC_ST_FAULT    = 5'd7;
    localparam logic [4:0] EXC_NO_TRAP     = 5'b1_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_nxt;
    logic [3:0]  cnt_q, cnt_nxt;
    logic [3:0]  oper_q, oper_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic        ready_nxt, valid_nxt;
    logic [31:0] rdata_nxt;
    logic [4:0]  exc_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    logic [3:0]    cur_oper;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [31:0]   offset;
    logic [IW-1:0] idx;
    logic [1:0]    lane;
    logic          is_load, is_store, undef, misaligned, out_of_range, fault, access;
    logic [1:0]    size;
    logic [4:0]    cls_exc;
    logic [31:0]   rd_word, ld_data;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          mem_we;

    // In IDLE the live request is classified; afterwards the latched copy is used
    assign cur_oper  = (state_q == S_IDLE) ? req_oper_i  : oper_q;
    assign cur_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
    assign cur_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
    assign offset    = cur_addr - BASE_ADDR;
    assign idx       = offset[IW+1:2];
    assign lane      = cur_addr[1:0];

    // Decode the operation and classify it in priority order
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        undef    = 1'b0;
        size     = 2'd0;
        case (cur_oper)
            OP_LB, OP_LBU: begin is_load = 1'b1;  size = 2'd0; end
            OP_LH, OP_LHU: begin is_load = 1'b1;  size = 2'd1; end
            OP_LW:         begin is_load = 1'b1;  size = 2'd2; end
            OP_SB:         begin is_store = 1'b1; size = 2'd0; end
            OP_SH:         begin is_store = 1'b1; size = 2'd1; end
            OP_SW:         begin is_store = 1'b1; size = 2'd2; end
            OP_NOP:        ;
            default:       undef = 1'b1;
        endcase
        misaligned   = (is_load || is_store) &&
                       ((size == 2'd1 && cur_addr[0]) || (size == 2'd2 && cur_addr[1:0] != 2'b00));
        out_of_range = {1'b0, offset} >= SPAN;
        fault        = 1'b1;
        if (misaligned) begin
            cls_exc = cur_oper[3] ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
        end else if (out_of_range || undef) begin
            cls_exc = cur_oper[3] ? EXC_ST_FAULT : EXC_LD_FAULT;
        end else begin
            cls_exc = EXC_NO_TRAP;
            fault   = 1'b0;
        end
        access = !fault && (is_load || is_store);
    end

    // Load lane extraction and store lane steering
    always_comb begin
        rd_word = mem[idx];
        byte_v  = 8'(rd_word >> {lane, 3'b000});
        half_v  = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (cur_oper)
            OP_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  ld_data = {24'd0, byte_v};
            OP_LH:   ld_data = {{16{half_v[15]}}, half_v};
            OP_LHU:  ld_data = {16'd0, half_v};
            OP_LW:   ld_data = rd_word;
            default: ld_data = 32'd0;
        endcase
        case (cur_oper)
            OP_SB: begin
                be = 4'(4'b0001 << lane);
                wd = {4{cur_wdata[7:0]}};
            end
            OP_SH: begin
                be = cur_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{cur_wdata[15:0]}};
            end
            OP_SW: begin
                be = 4'b1111;
                wd = cur_wdata;
            end
            default: begin
                be = 4'b0000;
                wd = cur_wdata;
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        oper_nxt  = oper_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        ready_nxt = req_ready_o;
        valid_nxt = rsp_valid_o;
        rdata_nxt = rsp_rdata_o;
        exc_nxt   = rsp_exc_o;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    oper_nxt  = req_oper_i;
                    addr_nxt  = req_addr_i;
                    wdata_nxt = req_wdata_i;
                    ready_nxt = 1'b0;
                    if (!access) begin
                        state_nxt = S_RESP;
                        valid_nxt = 1'b1;
                        rdata_nxt = 32'd0;
                        exc_nxt   = cls_exc;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_nxt = S_RESP;
                        valid_nxt = 1'b1;
                        rdata_nxt = is_load ? ld_data : 32'd0;
                        exc_nxt   = EXC_NO_TRAP;
                        mem_we    = is_store;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_nxt = S_RESP;
                    valid_nxt = 1'b1;
                    rdata_nxt = is_load ? ld_data : 32'd0;
                    exc_nxt   = EXC_NO_TRAP;
                    mem_we    = is_store;
                end else begin
                    cnt_nxt = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = S_IDLE;
                    ready_nxt = 1'b1;
                    valid_nxt = 1'b0;
                    rdata_nxt = 32'd0;
                    exc_nxt   = EXC_NO_TRAP;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            oper_q      <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'd0;
            rsp_exc_o   <= EXC_NO_TRAP;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            oper_q      <= oper_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            req_ready_o <= ready_nxt;
            rsp_valid_o <= valid_nxt;
            rsp_rdata_o <= rdata_nxt;
            rsp_exc_o   <= exc_nxt;
        end
    end

    // Byte-masked array write on entry into RESP; a reset on that edge drops it
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on the default-parameter
// instance plus hand-written backpressure and reset-in-WAIT sequences.
module tb_dmem_responder;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_NOP = 4'b1111;
    localparam logic [4:0] NT     = 5'b1_0000;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;
    logic [3:0]  oper;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata [3];
    logic [4:0]  exc [3];

    int checks = 0;
    int errors = 0;

    // u0: defaults (WAIT_STATES=1); u1: WAIT_STATES=3; u2: WAIT_STATES=2
    dmem_responder u0 (
        .clk_i(clk), .rst_i(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_oper_i(oper), .req_addr_i(addr), .req_wdata_i(wdata),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rdata[0]), .rsp_exc_o(exc[0])
    );
    dmem_responder #(.WAIT_STATES(3)) u1 (
        .clk_i(clk), .rst_i(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_oper_i(oper), .req_addr_i(addr), .req_wdata_i(wdata),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rdata[1]), .rsp_exc_o(exc[1])
    );
    dmem_responder #(.WAIT_STATES(2)) u2 (
        .clk_i(clk), .rst_i(rst[2]), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
        .req_oper_i(oper), .req_addr_i(addr), .req_wdata_i(wdata),
        .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]),
        .rsp_rdata_o(rdata[2]), .rsp_exc_o(exc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [4:0]  ex;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edge then settle: all sampling and driving happens 1 time unit after posedge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with rsp_ready held high; lat = edges from accept to rsp_valid seen
    task automatic txn(input int d, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic [4:0] ex, output int lat);
        int n;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            step();
            n++;
        end
        chk("ready_wait", 32'(req_ready[d]), 32'd1);
        oper = op;
        addr = a;
        wdata = wd;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b1;
        step();
        req_valid[d] = 1'b0;
        oper = 4'hF;
        addr = 32'hFFFF_FFFF;
        wdata = 32'hFFFF_FFFF;
        lat = 1;
        while (!rsp_valid[d] && lat < 50) begin
            step();
            lat++;
        end
        rd = rdata[d];
        ex = exc[d];
        step();
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        logic [4:0]  ex;
        int          lat;
        int          t;

        rst = 3'b111;
        req_valid = 3'b000;
        rsp_ready = 3'b000;
        oper = 4'd0;
        addr = 32'd0;
        wdata = 32'd0;
        repeat (3) step();
        rst = 3'b000;

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d_ready", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("rst%0d_valid", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("rst%0d_rdata", d), rdata[d], 32'd0);
            chk($sformatf("rst%0d_exc", d), 32'(exc[d]), 32'(NT));
        end

        vecs.push_back('{"sw_word",     OP_SW,  32'h8000_0004, 32'hDEAD_BEEF, 32'h0,         NT,    2});
        vecs.push_back('{"lb_hi",       OP_LB,  32'h8000_0007, 32'h0,         32'hFFFF_FFDE, NT,    2});
        vecs.push_back('{"lbu_hi",      OP_LBU, 32'h8000_0007, 32'h0,         32'h0000_00DE, NT,    2});
        vecs.push_back('{"lh_hi",       OP_LH,  32'h8000_0006, 32'h0,         32'hFFFF_DEAD, NT,    2});
        vecs.push_back('{"lhu_lo",      OP_LHU, 32'h8000_0004, 32'h0,         32'h0000_BEEF, NT,    2});
        vecs.push_back('{"lh_lo",       OP_LH,  32'h8000_0004, 32'h0,         32'hFFFF_BEEF, NT,    2});
        vecs.push_back('{"sb_lane1",    OP_SB,  32'h8000_0005, 32'hFFFF_FF12, 32'h0,         NT,    2});
        vecs.push_back('{"lw_after_sb", OP_LW,  32'h8000_0004, 32'h0,         32'hDEAD_12EF, NT,    2});
        vecs.push_back('{"lbu_lane1",   OP_LBU, 32'h8000_0005, 32'h0,         32'h0000_0012, NT,    2});
        vecs.push_back('{"sh_upper",    OP_SH,  32'h8000_0006, 32'hFFFF_A5A5, 32'h0,         NT,    2});
        vecs.push_back('{"lw_after_sh", OP_LW,  32'h8000_0004, 32'h0,         32'hA5A5_12EF, NT,    2});
        vecs.push_back('{"sw_word0",    OP_SW,  32'h8000_0000, 32'h1122_3344, 32'h0,         NT,    2});
        vecs.push_back('{"sh_misal",    OP_SH,  32'h8000_0001, 32'hFFFF_FFFF, 32'h0,         5'd6,  1});
        vecs.push_back('{"lw_unchanged",OP_LW,  32'h8000_0000, 32'h0,         32'h1122_3344, NT,    2});
        vecs.push_back('{"lw_misal",    OP_LW,  32'h8000_0002, 32'h0,         32'h0,         5'd4,  1});
        vecs.push_back('{"lw_range_lo", OP_LW,  32'h0000_0000, 32'h0,         32'h0,         5'd5,  1});
        vecs.push_back('{"lb_range_wr", OP_LB,  32'h7FFF_FFFF, 32'h0,         32'h0,         5'd5,  1});
        vecs.push_back('{"sw_range_hi", OP_SW,  32'h8000_1000, 32'h0BAD_0BAD, 32'h0,         5'd7,  1});
        vecs.push_back('{"sw_last",     OP_SW,  32'h8000_0FFC, 32'hCAFE_F00D, 32'h0,         NT,    2});
        vecs.push_back('{"lw_last",     OP_LW,  32'h8000_0FFC, 32'h0,         32'hCAFE_F00D, NT,    2});
        vecs.push_back('{"lb_last",     OP_LB,  32'h8000_0FFF, 32'h0,         32'hFFFF_FFCA, NT,    2});
        vecs.push_back('{"undef_ld",    4'b0011,32'h8000_0000, 32'h0,         32'h0,         5'd5,  1});
        vecs.push_back('{"undef_st",    4'b1110,32'h8000_0000, 32'h0,         32'h0,         5'd7,  1});
        vecs.push_back('{"nop",         OP_NOP, 32'h8000_0000, 32'h0,         32'h0,         NT,    1});
        vecs.push_back('{"lw_after_all",OP_LW,  32'h8000_0000, 32'h0,         32'h1122_3344, NT,    2});

        foreach (vecs[i]) begin
            txn(0, vecs[i].op, vecs[i].a, vecs[i].wd, rd, ex, lat);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].rd);
            chk({vecs[i].name, "_exc"}, 32'(ex), 32'(vecs[i].ex));
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure on WAIT_STATES=3 instance
        txn(1, OP_SW, 32'h8000_0020, 32'h5555_AAAA, rd, ex, lat);
        chk("bp_sw_lat", 32'(lat), 32'd4);
        oper = OP_LW;
        addr = 32'h8000_0020;
        req_valid[1] = 1'b1;
        rsp_ready[1] = 1'b0;
        step();
        req_valid[1] = 1'b0;
        oper = OP_SW;
        addr = 32'h8000_0020;
        wdata = 32'h0;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("bp_wait%0d_valid", k), 32'(rsp_valid[1]), 32'd0);
            chk($sformatf("bp_wait%0d_ready", k), 32'(req_ready[1]), 32'd0);
            step();
        end
        chk("bp_valid_rise", 32'(rsp_valid[1]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            req_valid[1] = 1'b1;
            step();
            chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid[1]), 32'd1);
            chk($sformatf("bp_hold%0d_rdata", k), rdata[1], 32'h5555_AAAA);
            chk($sformatf("bp_hold%0d_exc", k), 32'(exc[1]), 32'(NT));
            chk($sformatf("bp_hold%0d_ready", k), 32'(req_ready[1]), 32'd0);
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        step();
        rsp_ready[1] = 1'b0;
        chk("bp_post_valid", 32'(rsp_valid[1]), 32'd0);
        chk("bp_post_ready", 32'(req_ready[1]), 32'd1);
        txn(1, OP_LW, 32'h8000_0020, 32'h0, rd, ex, lat);
        chk("bp_no_write_rdata", rd, 32'h5555_AAAA);

        // Reset in first WAIT cycle on WAIT_STATES=2 instance
        txn(2, OP_SW, 32'h8000_0010, 32'h0, rd, ex, lat);
        chk("rw_init_lat", 32'(lat), 32'd3);
        oper = OP_SW;
        addr = 32'h8000_0010;
        wdata = 32'h1234_5678;
        req_valid[2] = 1'b1;
        step();
        req_valid[2] = 1'b0;
        chk("rw_in_wait_ready", 32'(req_ready[2]), 32'd0);
        rst[2] = 1'b1;
        step();
        rst[2] = 1'b0;
        chk("rw_rst_ready", 32'(req_ready[2]), 32'd1);
        chk("rw_rst_valid", 32'(rsp_valid[2]), 32'd0);
        chk("rw_rst_rdata", rdata[2], 32'd0);
        chk("rw_rst_exc", 32'(exc[2]), 32'(NT));
        t = 0;
        repeat (4) begin
            step();
            t++;
            chk($sformatf("rw_idle%0d_valid", t), 32'(rsp_valid[2]), 32'd0);
        end
        txn(2, OP_LW, 32'h8000_0010, 32'h0, rd, ex, lat);
        chk("rw_lw_rdata", rd, 32'h0);
        chk("rw_lw_exc", 32'(ex), 32'(NT));
        chk("rw_lw_lat", 32'(lat), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
